fft_out_reorder: RTL and testbench

- Output end of the 32-point radix-2 MDC FFT pipeline.
- Accepts the dual-path (upper/lower) bit-reversed result pairs from the last butterfly stage.
- Buffers one full frame in a ping-pong register bank and emits it as a single natural-order serial stream (X[0]..X[31]) under a valid/ready handshake.
- Mirror image of the stage-1 input commutator, which splits a stream onto two paths.

---
 rtl/fft_out_reorder_if.sv | 42 ++++
 rtl/fft_out_reorder.sv | 150 +++++++++++++++
 tb/tb_fft_out_reorder.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_out_reorder_if.sv
// fft_out_reorder_if: pair-in / serial-out stream bundle
// for the FFT output reorder buffer.
interface fft_out_reorder_if #(
  parameter int WIDTH = 9
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_first;
  logic signed [WIDTH-1:0] in_up_re;
  logic signed [WIDTH-1:0] in_up_im;
  logic signed [WIDTH-1:0] in_l_re;
  logic signed [WIDTH-1:0] in_l_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;
  logic [4:0]              out_index;
  logic                    out_last;
  logic                    sync_err;

  modport slave (
    input  in_valid, in_first,
    input  in_up_re, in_up_im,
    input  in_l_re, in_l_im,
    input  out_ready,
    output in_ready,
    output out_valid, out_re, out_im,
    output out_index, out_last,
    output sync_err
  );

  modport master (
    output in_valid, in_first,
    output in_up_re, in_up_im,
    output in_l_re, in_l_im,
    output out_ready,
    input  in_ready,
    input  out_valid, out_re, out_im,
    input  out_index, out_last,
    input  sync_err
  );
endinterface

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong bit-reversal buffer, 32-pt MDC FFT.
// Optional FFT_REORDER_SYNC_EN adds in_first frame-sync checking.
module fft_out_reorder #(
  parameter int WIDTH = 9,
  parameter int N     = 32
) (
  input logic             clk,
  input logic             rst_n,
  fft_out_reorder_if.slave io
);
  localparam int AW = $clog2(N);
  localparam int KW = AW - 1;
  localparam logic [KW-1:0] K_LAST = KW'(N/2 - 1);
  localparam logic [AW-1:0] R_LAST = AW'(N - 1);

  function automatic logic [4:0] bitrev5(
    input logic [4:0] v
  );
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  logic signed [WIDTH-1:0] bank_re [2][N];
  logic signed [WIDTH-1:0] bank_im [2][N];

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic [KW-1:0] wr_cnt;
  logic [KW-1:0] wr_cnt_nxt;
  logic [KW-1:0] wr_k;
  logic [AW-1:0] rd_cnt;
  logic [4:0]    up_addr;
  logic [4:0]    lo_addr;

  logic wr_fire;
  logic wr_en;
  logic wr_done;
  logic restart;
  logic drop;
  logic rd_fire;
  logic rd_done;
  logic out_valid;

  assign io.in_ready = !full[wr_bank];
  assign wr_fire     = io.in_valid & io.in_ready;

`ifdef FFT_REORDER_SYNC_EN
  logic sync_err_q;

  assign restart = wr_fire & io.in_first
                 & (wr_cnt != '0);
  assign drop    = wr_fire & !io.in_first
                 & (wr_cnt == '0);

  // sticky frame-sync error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_q <= 1'b0;
    end else if (restart | drop) begin
      sync_err_q <= 1'b1;
    end
  end

  assign io.sync_err = sync_err_q;
`else
  logic unused_first;

  assign unused_first = io.in_first;
  assign restart      = 1'b0;
  assign drop         = 1'b0;
  assign io.sync_err  = 1'b0;
`endif

  assign wr_en   = wr_fire & !drop;
  assign wr_k    = restart ? '0 : wr_cnt;
  assign wr_done = wr_en & (wr_k == K_LAST);
  assign up_addr = bitrev5({wr_k, 1'b0});
  assign lo_addr = bitrev5({wr_k, 1'b1});

  // next pair counter: restart lands on k=1
  always_comb begin
    wr_cnt_nxt = wr_cnt;
    unique case (1'b1)
      restart: wr_cnt_nxt = KW'(1);
      wr_en:   wr_cnt_nxt = wr_cnt + KW'(1);
      default: wr_cnt_nxt = wr_cnt;
    endcase
  end

  assign out_valid = full[rd_bank];
  assign rd_fire   = out_valid & io.out_ready;
  assign rd_done   = rd_fire & (rd_cnt == R_LAST);

  // set and clear never hit the same bank
  always_comb begin
    full_nxt = full;
    if (wr_done) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (rd_done) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  // sample storage, scattered to bit-reversed slots
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_re[wr_bank][up_addr] <= io.in_up_re;
      bank_im[wr_bank][up_addr] <= io.in_up_im;
      bank_re[wr_bank][lo_addr] <= io.in_l_re;
      bank_im[wr_bank][lo_addr] <= io.in_l_im;
    end
  end

  // bank pointers, counters and full flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      full   <= full_nxt;
      wr_cnt <= wr_cnt_nxt;
      if (wr_done) begin
        wr_bank <= !wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + AW'(1);
      end
      if (rd_done) begin
        rd_bank <= !rd_bank;
      end
    end
  end

  assign io.out_valid = out_valid;
  assign io.out_re    = out_valid
                      ? bank_re[rd_bank][rd_cnt]
                      : '0;
  assign io.out_im    = out_valid
                      ? bank_im[rd_bank][rd_cnt]
                      : '0;
  assign io.out_index = rd_cnt;
  assign io.out_last  = out_valid
                      & (rd_cnt == R_LAST);

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: random and directed frames checked
// against a natural-order frame queue.
module tb_fft_out_reorder;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fft_out_reorder_if #(.WIDTH(W)) bus ();

  fft_out_reorder #(
    .WIDTH(W),
    .N(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit drv_to;

  logic signed [W-1:0] frm_re [32];
  logic signed [W-1:0] frm_im [32];
  logic signed [W-1:0] q_re [$];
  logic signed [W-1:0] q_im [$];
  logic [4:0]          q_idx [$];

  function automatic logic [4:0] brev(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  // natural-order frame X[0..31]
  task automatic make_frame(input int mode);
    for (int i = 0; i < 32; i++) begin
      if (mode == 0) begin
        frm_re[i] = W'(i);
        frm_im[i] = W'(-i);
      end else begin
        frm_re[i] = W'($urandom);
        frm_im[i] = W'($urandom);
      end
    end
    if (mode == 2) begin
      for (int k = 0; k < 16; k++) begin
        frm_re[brev(5'(2*k))]   = W'(-256);
        frm_im[brev(5'(2*k))]   = W'(255);
        frm_re[brev(5'(2*k+1))] = W'(255);
        frm_im[brev(5'(2*k+1))] = W'(-256);
      end
    end
  endtask

  // send frames as bit-reversed pairs; full frames
  // are queued as expected natural-order output
  task automatic feed(input int nfr, input int mode,
                      input int npairs, input int first_at);
    for (int f = 0; f < nfr; f++) begin
      int k = 0;
      int cyc = 0;
      make_frame(mode);
      if (npairs == 16) begin
        for (int i = 0; i < 32; i++) begin
          q_re.push_back(frm_re[i]);
          q_im.push_back(frm_im[i]);
          q_idx.push_back(5'(i));
        end
      end
      while (k < npairs && cyc < 4000) begin
        @(negedge clk);
        cyc++;
        bus.in_valid = 1'b1;
        bus.in_first = (k == 0) || (k == first_at);
        bus.in_up_re = frm_re[brev(5'(2*k))];
        bus.in_up_im = frm_im[brev(5'(2*k))];
        bus.in_l_re  = frm_re[brev(5'(2*k+1))];
        bus.in_l_im  = frm_im[brev(5'(2*k+1))];
        if (bus.in_ready) k++;
      end
      if (k < npairs) drv_to = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_first = 0;
    bus.in_up_re = 0; bus.in_up_im = 0;
    bus.in_l_re = 0; bus.in_l_im = 0;
    bus.out_ready = 0;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_last,
         bus.sync_err} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags: got rdy=%b vld=%b last=%b err=%b want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_last, bus.sync_err);
    end
    n_cmp++;
    if ({bus.out_re, bus.out_im, bus.out_index} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got re=%0d im=%0d idx=%0d want 0 0 0",
               bus.out_re, bus.out_im, bus.out_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int got = 0;
    int cyc = 0;
    int first_v = -1;
    drv_to = 0;
    fork
      feed(1, 0, 16, -1);
      while (got < 32 && cyc < 400) begin
        @(negedge clk);
        cyc++;
        bus.out_ready = 1'b1;
        n_cmp++;
        if (!bus.out_valid) begin
          if ({bus.out_re, bus.out_im, bus.out_last} !== '0) begin
            n_err++;
            $display("FAIL single_idle: got re=%0d im=%0d last=%b want 0",
                     bus.out_re, bus.out_im, bus.out_last);
          end
        end else begin
          if (first_v < 0) first_v = cyc;
          if (q_re.size() == 0) begin
            n_err++;
            $display("FAIL single_extra: got idx=%0d want no sample",
                     bus.out_index);
          end else begin
            if ({bus.out_re, bus.out_im, bus.out_index, bus.out_last}
                !== {q_re[0], q_im[0], q_idx[0], q_idx[0] == 5'd31}) begin
              n_err++;
              $display("FAIL single_sample: got re=%0d im=%0d idx=%0d last=%b want re=%0d im=%0d idx=%0d",
                       bus.out_re, bus.out_im, bus.out_index, bus.out_last,
                       q_re[0], q_im[0], q_idx[0]);
            end
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            void'(q_idx.pop_front());
          end
          got++;
        end
      end
    join
    n_cmp++;
    if (first_v !== 17) begin
      n_err++;
      $display("FAIL single_latency: got cycle %0d want 17", first_v);
    end
    n_cmp++;
    if (got !== 32 || drv_to) begin
      n_err++;
      $display("FAIL single_count: got %0d timeout=%b want 32 0", got, drv_to);
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int cyc = 0;
    bit blocked = 0;
    drv_to = 0;
    fork
      feed(3, 1, 16, -1);
      while (got < 96 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
        bus.out_ready = 1'b1;
        if (bus.in_valid && !bus.in_ready) blocked = 1;
        if (bus.out_valid) begin
          n_cmp++;
          if (q_re.size() == 0) begin
            n_err++;
            $display("FAIL b2b_extra: got idx=%0d want no sample",
                     bus.out_index);
          end else begin
            if ({bus.out_re, bus.out_im, bus.out_index, bus.out_last}
                !== {q_re[0], q_im[0], q_idx[0], q_idx[0] == 5'd31}) begin
              n_err++;
              $display("FAIL b2b_sample: got re=%0d im=%0d idx=%0d last=%b want re=%0d im=%0d idx=%0d",
                       bus.out_re, bus.out_im, bus.out_index, bus.out_last,
                       q_re[0], q_im[0], q_idx[0]);
            end
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            void'(q_idx.pop_front());
          end
          got++;
        end
      end
    join
    n_cmp++;
    if (blocked !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_backpressure: got in_ready stall=%b want 1", blocked);
    end
    n_cmp++;
    if (got !== 96 || drv_to || q_re.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: got %0d left=%0d want 96 0",
               got, q_re.size());
    end
  endtask

  task automatic test_stall();
    int got = 0;
    int cyc = 0;
    int stalls = 0;
    drv_to = 0;
    fork
      feed(2, 1, 16, -1);
      while (got < 64 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
        bus.out_ready = cyc[0];
        if (bus.out_valid) begin
          if (!bus.out_ready) stalls++;
          n_cmp++;
          if (q_re.size() == 0) begin
            n_err++;
            $display("FAIL stall_extra: got idx=%0d want no sample",
                     bus.out_index);
          end else begin
            if ({bus.out_re, bus.out_im, bus.out_index, bus.out_last}
                !== {q_re[0], q_im[0], q_idx[0], q_idx[0] == 5'd31}) begin
              n_err++;
              $display("FAIL stall_sample: got re=%0d im=%0d idx=%0d last=%b want re=%0d im=%0d idx=%0d rdy=%b",
                       bus.out_re, bus.out_im, bus.out_index, bus.out_last,
                       q_re[0], q_im[0], q_idx[0], bus.out_ready);
            end
            if (bus.out_ready) begin
              void'(q_re.pop_front());
              void'(q_im.pop_front());
              void'(q_idx.pop_front());
              got++;
            end
          end
        end
      end
    join
    bus.out_ready = 1'b1;
    n_cmp++;
    if (got !== 64 || drv_to || stalls < 32) begin
      n_err++;
      $display("FAIL stall_count: got %0d stalls=%0d want 64 >=32",
               got, stalls);
    end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    int cyc = 0;
    int first_v = -1;
    drv_to = 0;
    feed(1, 1, 8, -1);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rstmid_flags: got rdy=%b vld=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fork
      feed(1, 0, 16, -1);
      while (got < 32 && cyc < 400) begin
        @(negedge clk);
        cyc++;
        bus.out_ready = 1'b1;
        if (bus.out_valid) begin
          if (first_v < 0) first_v = cyc;
          n_cmp++;
          if (q_re.size() == 0) begin
            n_err++;
            $display("FAIL rstmid_extra: got idx=%0d want no sample",
                     bus.out_index);
          end else begin
            if ({bus.out_re, bus.out_im, bus.out_index}
                !== {q_re[0], q_im[0], q_idx[0]}) begin
              n_err++;
              $display("FAIL rstmid_sample: got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                       bus.out_re, bus.out_im, bus.out_index,
                       q_re[0], q_im[0], q_idx[0]);
            end
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            void'(q_idx.pop_front());
          end
          got++;
        end
      end
    join
    n_cmp++;
    if (first_v !== 17 || got !== 32 || drv_to) begin
      n_err++;
      $display("FAIL rstmid_latency: got first=%0d n=%0d want 17 32",
               first_v, got);
    end
  endtask

  task automatic test_extremes();
    int got = 0;
    int cyc = 0;
    int n_min = 0;
    drv_to = 0;
    fork
      feed(1, 2, 16, -1);
      while (got < 32 && cyc < 400) begin
        @(negedge clk);
        cyc++;
        bus.out_ready = 1'b1;
        if (bus.out_valid) begin
          if (bus.out_re == -256) n_min++;
          n_cmp++;
          if (q_re.size() == 0) begin
            n_err++;
            $display("FAIL extreme_extra: got idx=%0d want no sample",
                     bus.out_index);
          end else begin
            if ({bus.out_re, bus.out_im, bus.out_index}
                !== {q_re[0], q_im[0], q_idx[0]}) begin
              n_err++;
              $display("FAIL extreme_sample: got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                       bus.out_re, bus.out_im, bus.out_index,
                       q_re[0], q_im[0], q_idx[0]);
            end
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            void'(q_idx.pop_front());
          end
          got++;
        end
      end
    join
    n_cmp++;
    if (n_min !== 16 || got !== 32 || drv_to) begin
      n_err++;
      $display("FAIL extreme_count: got min=%0d n=%0d want 16 32",
               n_min, got);
    end
  endtask

  task automatic test_sync();
    int got = 0;
    int cyc = 0;
    logic want_err;
    drv_to = 0;
`ifdef FFT_REORDER_SYNC_EN
    want_err = 1'b1;
    feed(1, 1, 5, -1);
    fork
      feed(1, 0, 16, -1);
`else
    want_err = 1'b0;
    fork
      feed(1, 0, 16, 5);
`endif
      while (got < 32 && cyc < 400) begin
        @(negedge clk);
        cyc++;
        bus.out_ready = 1'b1;
        if (bus.out_valid) begin
          n_cmp++;
          if (q_re.size() == 0) begin
            n_err++;
            $display("FAIL sync_extra: got idx=%0d want no sample",
                     bus.out_index);
          end else begin
            if ({bus.out_re, bus.out_im, bus.out_index}
                !== {q_re[0], q_im[0], q_idx[0]}) begin
              n_err++;
              $display("FAIL sync_sample: got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                       bus.out_re, bus.out_im, bus.out_index,
                       q_re[0], q_im[0], q_idx[0]);
            end
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            void'(q_idx.pop_front());
          end
          got++;
        end
      end
    join
    n_cmp++;
    if (bus.sync_err !== want_err) begin
      n_err++;
      $display("FAIL sync_err: got %b want %b", bus.sync_err, want_err);
    end
    n_cmp++;
    if (got !== 32 || drv_to) begin
      n_err++;
      $display("FAIL sync_count: got %0d want 32", got);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_extremes();
    test_sync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
